fpu_wb_commit: RTL and testbench
================================

Name: fpu_wb_commit

Overview:
- Result-side end of the FAlu interface: accepts FAlu results with their IEEE exception flags and buffers them in a FIFO.
- Commits each result in order to the FP register file write port through a valid/ready handshake.
- Owns the architectural FCSR0 register: accrues Flags, sets Cause and raises FP exception traps.
- Drives FCSR0 back to FAlu (rounding mode, enables); sits between FAlu and the FP regfile/commit logic.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >= 2)
- WIDTH_FALU, 32, FCSR width; result data is WIDTH_FALU*2
- ADDR_W, 5, architectural FP register address width

Ports:
- Clk  in  1  clock
- Rest  in  1  asynchronous active-low reset
- InValid  in  1  FAlu result valid
- InReady  out  1  unit can accept a result
- InRdAddr  in  ADDR_W  destination FP register
- InRdData  in  64  result data
- InExcFlags  in  5  {V,Z,O,U,I}, I = bit0
- InPc  in  32  instruction PC
- WbValid  out  1  regfile write request
- WbReady  in  1  regfile accepts write
- WbRdAddr  out  ADDR_W  write address
- WbRdData  out  64  write data
- FcsrWrEn  in  1  movgr2fcsr write strobe
- FcsrWrSel  in  2  target: fcsr0..fcsr3
- FcsrWrData  in  32  write value
- OutFcsr0  out  32  current FCSR0 to FAlu
- TrapValid  out  1  FP exception trap pending
- TrapPc  out  32  PC of trapping instruction
- TrapAck  in  1  trap taken by commit logic
- Flush  in  1  pipeline flush

Behaviour:
- FCSR0 fields: Enables[4:0], RM[9:8], Flags[20:16], Cause[28:24]. All other bits read 0.
- Reset (Rest=0, async): FIFO empty, state RUN, FCSR0=0, InReady=0 while in reset, WbValid=0, TrapValid=0, TrapPc=0, WbRdAddr=0, WbRdData=0.
- States:
  - RUN: normal operation.
  - TRAP: exception hold.
  - RUN->TRAP on commit of an entry with (flags & Enables) != 0.
  - TRAP->RUN on TrapAck.
- Push: InValid && InReady writes {addr, data, flags, pc} at the tail.
  - InReady = (state==RUN) && !full && !Flush.
  - Push and pop in the same cycle are allowed when full: count is unchanged, InReady stays asserted only if a pop occurs that cycle (InReady is combinationally dependent on the pop).
- Head presentation: WbValid = (state==RUN) && !empty && !FcsrWrEn && !trapping_head.
  - WbRdAddr/WbRdData come from the FIFO head and stay stable while WbValid && !WbReady.
  - Latency: push in cycle N -> WbValid in cycle N+1 if the FIFO was empty.
- Commit of a non-trapping head (WbValid && WbReady, i.e. (flags & Enables)==0):
  - Pop the head.
  - Cause <= flags.
  - Flags <= Flags | flags.
- Trapping head (flags & Enables != 0), taken in the cycle the head is presented with state RUN and no FcsrWrEn:
  - No register write (WbValid=0).
  - Cause <= flags; Flags unchanged.
  - TrapPc <= pc; TrapValid = 1 from the next cycle.
  - Entire FIFO discarded.
  - Enter TRAP. InReady=0 and WbValid=0 until TrapAck; TrapValid deasserts the cycle after TrapAck.
- FCSR writes (FcsrWrEn), applied at the clock edge:
  - sel0: FCSR0 <= FcsrWrData & 0x1F1F031F.
  - sel1: Enables <= data[4:0].
  - sel2: Flags <= data[20:16]; Cause <= data[28:24].
  - sel3: RM <= data[9:8].
  - An FCSR write and a commit never coincide, because FcsrWrEn suppresses WbValid (and trap detection) that cycle; the head commits the following cycle using the new Enables.
- Flush (synchronous):
  - Empties the FIFO; WbValid=0 that cycle; InReady=0 that cycle.
  - FCSR0 is unchanged.
  - In TRAP state, Flush does not clear TrapValid; only TrapAck does.
- Pointers are log2(DEPTH) bits with a separate count (0..DEPTH); wrap-around is natural modulo DEPTH.
- OutFcsr0 is the registered FCSR0 with no bypass of same-cycle writes.

Optional Feature:
- Macro FPU_WB_BYPASS_EN.
- Defined: when the FIFO is empty and state==RUN, an incoming InValid is presented on WbValid/WbRdAddr/WbRdData combinationally in the same cycle, with the same trap/flag rules.
  - If WbReady is also high (and the entry is non-trapping), it commits without being written to the FIFO; otherwise it is pushed normally.
  - Zero-cycle latency.
- Undefined: strict one-cycle minimum latency through the FIFO.

Test Plan:
- Reset then 4 back-to-back pushes (addr 1..4, flags 0) with WbReady=1 -> four writes in order, addresses 1,2,3,4, starting the cycle after the first push; FCSR0 stays 0.
- Fill all 4 entries with WbReady=0 -> InReady=0 after 4th push. Assert WbReady for 1 cycle with a simultaneous push -> count stays 4 and the new entry commits last.
- Enables=0, commit flags I (5'b00001) then O (5'b00100) -> Cause=5'b00100, Flags=5'b00101, so FCSR0=0x04050000.
- Write fcsr1=0x1 (I enabled), queue entries A (flags 0, pc 0x1C000100), B (flags I, pc 0x1C000104), C (flags 0):
  - A is written; B is not written.
  - TrapValid=1, TrapPc=0x1C000104, Cause=1, C discarded.
  - TrapAck -> RUN, FIFO empty.
- FcsrWrEn (sel3, data 0x300) in the same cycle the head is valid -> WbValid=0 that cycle, RM=2'b11 next cycle, head commits the following cycle.
- Flush with 3 entries queued -> FIFO empty, no writes, FCSR0 unchanged; with FPU_WB_BYPASS_EN, a push into the empty FIFO with WbReady=1 -> WbValid in the same cycle.

Source files
------------

// File: rtl/fpu_wb_commit.sv
// fpu_wb_commit: result-side end of the FAlu interface.
//   Buffers FAlu results (with IEEE exception flags and PC) in a FIFO, commits
//   them in order to the FP register file write port over valid/ready, owns the
//   architectural FCSR0 (Enables/RM/Flags/Cause) and raises FP exception traps.
//   Optional feature macro FPU_WB_BYPASS_EN: zero-latency bypass of an incoming
//   result straight to the write port when the FIFO is empty.
// Ports:
//   Clk, Rest                  clock, asynchronous active-low reset
//   InValid/InReady            FAlu result handshake
//   InRdAddr/InRdData          destination register and result data
//   InExcFlags/InPc            {V,Z,O,U,I} flags and instruction PC
//   WbValid/WbReady            regfile write handshake
//   WbRdAddr/WbRdData          write address and data (FIFO head)
//   FcsrWrEn/FcsrWrSel/FcsrWrData  movgr2fcsr write port (fcsr0..fcsr3 views)
//   OutFcsr0                   registered FCSR0 to FAlu
//   TrapValid/TrapPc/TrapAck   FP exception trap to commit logic
//   Flush                      synchronous pipeline flush
module fpu_wb_commit #(
  parameter int DEPTH      = 4,
  parameter int WIDTH_FALU = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [ADDR_W-1:0]       InRdAddr,
  input  logic [2*WIDTH_FALU-1:0] InRdData,
  input  logic [4:0]              InExcFlags,
  input  logic [31:0]             InPc,
  output logic                    WbValid,
  input  logic                    WbReady,
  output logic [ADDR_W-1:0]       WbRdAddr,
  output logic [2*WIDTH_FALU-1:0] WbRdData,
  input  logic                    FcsrWrEn,
  input  logic [1:0]              FcsrWrSel,
  input  logic [WIDTH_FALU-1:0]   FcsrWrData,
  output logic [WIDTH_FALU-1:0]   OutFcsr0,
  output logic                    TrapValid,
  output logic [31:0]             TrapPc,
  input  logic                    TrapAck,
  input  logic                    Flush
);
  localparam int DATA_W = 2 * WIDTH_FALU;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {S_RUN, S_TRAP} state_t;
  state_t state, state_nxt;

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [4:0]        mem_flags [DEPTH];
  logic [31:0]       mem_pc    [DEPTH];

  logic [4:0] enables, flags, cause;
  logic [1:0] rm;
  logic [31:0] trap_pc;

  logic full, empty, running, use_byp;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_data;
  logic [4:0]        cand_flags;
  logic [31:0]       cand_pc;
  logic cand_valid, cand_trap, trap_take, commit, pop, push, fifo_clear;

  // Upper/reserved FCSR write bits have no storage.
  logic unused_fcsr_bits;
  assign unused_fcsr_bits = ^{FcsrWrData[WIDTH_FALU-1:29], FcsrWrData[23:21],
                              FcsrWrData[15:10], FcsrWrData[7:5]};

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Gating with Rest keeps both handshakes quiet while reset is held.
  assign running = (state == S_RUN) && Rest;

`ifdef FPU_WB_BYPASS_EN
  assign use_byp = empty && running && InValid;
`else
  assign use_byp = 1'b0;
`endif

  // Candidate for commit: FIFO head, or the incoming result when bypassing.
  always_comb begin
    cand_addr  = mem_addr[head];
    cand_data  = mem_data[head];
    cand_flags = mem_flags[head];
    cand_pc    = mem_pc[head];
    if (use_byp) begin
      cand_addr  = InRdAddr;
      cand_data  = InRdData;
      cand_flags = InExcFlags;
      cand_pc    = InPc;
    end
  end

  // An FCSR write or flush hides the head for one cycle so the head is always
  // judged against settled Enables.
  assign cand_valid = running && (!empty || use_byp) && !FcsrWrEn && !Flush;
  assign cand_trap  = |(cand_flags & enables);
  assign trap_take  = cand_valid && cand_trap;
  assign commit     = WbValid && WbReady;
  assign pop        = commit && !use_byp;
  // A bypassed entry that commits never lands in the FIFO.
  assign push       = InValid && InReady && !(use_byp && commit);
  assign fifo_clear = Flush || trap_take;

  // FSM: state register
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) state <= S_RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (trap_take) state_nxt = S_TRAP;
      S_TRAP:  if (TrapAck)   state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // FSM: outputs. A FIFO-head trap refuses input that cycle because the
  // whole FIFO is discarded; a bypassed trapping entry is consumed instead.
  always_comb begin
    TrapValid = (state == S_TRAP);
    WbValid   = cand_valid && !cand_trap;
    InReady   = running && !Flush && !(trap_take && !use_byp) && (!full || pop);
    WbRdAddr  = '0;
    WbRdData  = '0;
    if (use_byp || !empty) begin
      WbRdAddr = cand_addr;
      WbRdData = cand_data;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fifo_clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_addr[tail]  <= InRdAddr;
      mem_data[tail]  <= InRdData;
      mem_flags[tail] <= InExcFlags;
      mem_pc[tail]    <= InPc;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      enables <= '0;
      rm      <= '0;
      flags   <= '0;
      cause   <= '0;
      trap_pc <= '0;
    end else begin
      if (FcsrWrEn) begin
        case (FcsrWrSel)
          2'd0: begin
            enables <= FcsrWrData[4:0];
            rm      <= FcsrWrData[9:8];
            flags   <= FcsrWrData[20:16];
            cause   <= FcsrWrData[28:24];
          end
          2'd1: enables <= FcsrWrData[4:0];
          2'd2: begin
            flags <= FcsrWrData[20:16];
            cause <= FcsrWrData[28:24];
          end
          default: rm <= FcsrWrData[9:8];
        endcase
      end else if (commit) begin
        cause <= cand_flags;
        flags <= flags | cand_flags;
      end else if (trap_take) begin
        cause <= cand_flags;
      end
      if (trap_take) trap_pc <= cand_pc;
    end
  end

  assign TrapPc   = trap_pc;
  assign OutFcsr0 = WIDTH_FALU'({3'b0, cause, 3'b0, flags, 6'b0, rm, 3'b0, enables});

endmodule

// File: tb/tb_fpu_wb_commit.sv
module tb_fpu_wb_commit;
`ifdef FPU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk, Rest;
  logic        InValid, InReady;
  logic [4:0]  InRdAddr;
  logic [63:0] InRdData;
  logic [4:0]  InExcFlags;
  logic [31:0] InPc;
  logic        WbValid, WbReady;
  logic [4:0]  WbRdAddr;
  logic [63:0] WbRdData;
  logic        FcsrWrEn;
  logic [1:0]  FcsrWrSel;
  logic [31:0] FcsrWrData;
  logic [31:0] OutFcsr0;
  logic        TrapValid;
  logic [31:0] TrapPc;
  logic        TrapAck, Flush;

  int checks = 0;
  int failures = 0;
  int wb_count = 0;
  logic [68:0] exp_q[$];

  fpu_wb_commit dut (
    .Clk(Clk), .Rest(Rest),
    .InValid(InValid), .InReady(InReady), .InRdAddr(InRdAddr), .InRdData(InRdData),
    .InExcFlags(InExcFlags), .InPc(InPc),
    .WbValid(WbValid), .WbReady(WbReady), .WbRdAddr(WbRdAddr), .WbRdData(WbRdData),
    .FcsrWrEn(FcsrWrEn), .FcsrWrSel(FcsrWrSel), .FcsrWrData(FcsrWrData),
    .OutFcsr0(OutFcsr0), .TrapValid(TrapValid), .TrapPc(TrapPc), .TrapAck(TrapAck),
    .Flush(Flush)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] data_of(input logic [4:0] a);
    return {32'hC0DE0000 | 32'(a), 32'h5A5A0000 + 32'(a)};
  endfunction

  // Scoreboard: every regfile write must match the oldest expected entry.
  always @(negedge Clk) begin
    logic [68:0] e;
    #1;
    if (Rest && WbValid && WbReady) begin
      wb_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got addr=%0d data=%h required no write", WbRdAddr, WbRdData);
      end else begin
        e = exp_q.pop_front();
        if ({WbRdAddr, WbRdData} !== e) begin
          failures++;
          $display("FAIL wb_order got addr=%0d data=%h required addr=%0d data=%h",
                   WbRdAddr, WbRdData, e[68:64], e[63:0]);
        end
      end
    end
  end

  task automatic drive_in(input logic [4:0] a, input logic [4:0] f, input logic [31:0] pc);
    InValid = 1'b1;
    InRdAddr = a;
    InRdData = data_of(a);
    InExcFlags = f;
    InPc = pc;
  endtask

  task automatic push(input logic [4:0] a, input logic [4:0] f, input logic [31:0] pc,
                      input bit exp_wr);
    int n = 0;
    drive_in(a, f, pc);
    @(negedge Clk);
    while (!InReady && n < 20) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!InReady) begin
      failures++;
      $display("FAIL push_timeout addr=%0d got InReady=0 required 1", a);
    end else if (exp_wr) begin
      exp_q.push_back({a, data_of(a)});
    end
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic fcsr_write(input logic [1:0] sel, input logic [31:0] d);
    FcsrWrEn = 1'b1;
    FcsrWrSel = sel;
    FcsrWrData = d;
    @(posedge Clk); #1;
    FcsrWrEn = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    Rest = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rst_inready got %b required 0", InReady); end
    checks++; if (WbValid !== 1'b0) begin failures++; $display("FAIL rst_wbvalid got %b required 0", WbValid); end
    checks++; if (TrapValid !== 1'b0) begin failures++; $display("FAIL rst_trapvalid got %b required 0", TrapValid); end
    checks++; if (TrapPc !== 32'h0) begin failures++; $display("FAIL rst_trappc got %h required 0", TrapPc); end
    checks++; if ({WbRdAddr, WbRdData} !== 69'h0) begin failures++; $display("FAIL rst_wbdata got %h required 0", {WbRdAddr, WbRdData}); end
    checks++; if (OutFcsr0 !== 32'h0) begin failures++; $display("FAIL rst_fcsr0 got %h required 0", OutFcsr0); end
    @(posedge Clk); #1;
    Rest = 1'b1;
    @(negedge Clk);
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL rst_release_inready got %b required 1", InReady); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [4:0] exp_a;
    wb_count = 0;
    WbReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_in(5'(i), 5'h0, 32'h1C000000 + 32'(i * 4));
      @(negedge Clk);
      exp_v = BYP ? 1'b1 : (i != 1);
      exp_a = BYP ? 5'(i) : 5'(i - 1);
      checks++;
      if (WbValid !== exp_v || (exp_v && WbRdAddr !== exp_a)) begin
        failures++;
        $display("FAIL b2b_latency cycle=%0d got valid=%b addr=%0d required valid=%b addr=%0d",
                 i, WbValid, WbRdAddr, exp_v, exp_a);
      end
      checks++;
      if (InReady !== 1'b1) begin
        failures++;
        $display("FAIL b2b_inready cycle=%0d got %b required 1", i, InReady);
      end else begin
        exp_q.push_back({5'(i), data_of(5'(i))});
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    wait_drain("b2b");
    checks++; if (wb_count != 4) begin failures++; $display("FAIL b2b_count got %0d required 4", wb_count); end
    checks++; if (OutFcsr0 !== 32'h0) begin failures++; $display("FAIL b2b_fcsr0 got %h required 0", OutFcsr0); end
  endtask

  task automatic test_full();
    WbReady = 1'b0;
    for (int i = 5; i <= 8; i++) push(5'(i), 5'h0, 32'h0, 1'b1);
    @(negedge Clk);
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL full_inready got %b required 0", InReady); end
    checks++; if (WbValid !== 1'b1 || WbRdAddr !== 5'd5) begin failures++; $display("FAIL full_head got valid=%b addr=%0d required 1/5", WbValid, WbRdAddr); end
    @(posedge Clk); #1;
    WbReady = 1'b1;
    drive_in(5'd9, 5'h0, 32'h0);
    @(negedge Clk);
    checks++;
    if (InReady !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop_inready got %b required 1", InReady);
    end else begin
      exp_q.push_back({5'd9, data_of(5'd9)});
    end
    @(posedge Clk); #1;
    WbReady = 1'b0;
    InValid = 1'b0;
    @(negedge Clk);
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL full_count_kept got InReady=%b required 0", InReady); end
    checks++; if (WbRdAddr !== 5'd6) begin failures++; $display("FAIL full_next_head got %0d required 6", WbRdAddr); end
    @(posedge Clk); #1;
    WbReady = 1'b1;
    wait_drain("full");
  endtask

  task automatic test_flags();
    fcsr_write(2'd0, 32'h0);
    WbReady = 1'b1;
    push(5'd1, 5'b00001, 32'h0, 1'b1);
    push(5'd2, 5'b00100, 32'h0, 1'b1);
    wait_drain("flags");
    checks++; if (OutFcsr0 !== 32'h04050000) begin failures++; $display("FAIL flags_fcsr0 got %h required 04050000", OutFcsr0); end
  endtask

  task automatic test_trap();
    int n = 0;
    fcsr_write(2'd1, 32'h1);
    WbReady = 1'b0;
    push(5'd10, 5'b00000, 32'h1C000100, 1'b1);
    push(5'd11, 5'b00001, 32'h1C000104, 1'b0);
    push(5'd12, 5'b00000, 32'h1C000108, 1'b0);
    WbReady = 1'b1;
    @(negedge Clk);
    while (!TrapValid && n < 20) begin @(negedge Clk); n++; end
    checks++; if (TrapValid !== 1'b1) begin failures++; $display("FAIL trap_valid got %b required 1", TrapValid); end
    checks++; if (TrapPc !== 32'h1C000104) begin failures++; $display("FAIL trap_pc got %h required 1C000104", TrapPc); end
    checks++; if (OutFcsr0 !== 32'h01050001) begin failures++; $display("FAIL trap_fcsr0 got %h required 01050001", OutFcsr0); end
    checks++; if (InReady !== 1'b0 || WbValid !== 1'b0) begin failures++; $display("FAIL trap_hold got inready=%b wbvalid=%b required 0/0", InReady, WbValid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL trap_a_written got pending=%0d required 0", exp_q.size()); end
    @(posedge Clk); #1;
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    @(negedge Clk);
    checks++; if (TrapValid !== 1'b1) begin failures++; $display("FAIL trap_flush_kept got %b required 1", TrapValid); end
    @(posedge Clk); #1;
    TrapAck = 1'b1;
    @(negedge Clk);
    checks++; if (TrapValid !== 1'b1) begin failures++; $display("FAIL trap_ack_cycle got %b required 1", TrapValid); end
    @(posedge Clk); #1;
    TrapAck = 1'b0;
    @(negedge Clk);
    checks++; if (TrapValid !== 1'b0) begin failures++; $display("FAIL trap_released got %b required 0", TrapValid); end
    checks++; if (InReady !== 1'b1 || WbValid !== 1'b0) begin failures++; $display("FAIL trap_run_empty got inready=%b wbvalid=%b required 1/0", InReady, WbValid); end
    @(posedge Clk); #1;
    fcsr_write(2'd1, 32'h0);
  endtask

  task automatic test_fcsr_hold();
    WbReady = 1'b0;
    push(5'd13, 5'h0, 32'h0, 1'b1);
    FcsrWrEn = 1'b1;
    FcsrWrSel = 2'd3;
    FcsrWrData = 32'h300;
    WbReady = 1'b1;
    @(negedge Clk);
    checks++; if (WbValid !== 1'b0) begin failures++; $display("FAIL fcsr_hold_wbvalid got %b required 0", WbValid); end
    @(posedge Clk); #1;
    FcsrWrEn = 1'b0;
    @(negedge Clk);
    checks++; if (OutFcsr0 !== 32'h01050300) begin failures++; $display("FAIL fcsr_rm got %h required 01050300", OutFcsr0); end
    checks++; if (WbValid !== 1'b1 || WbRdAddr !== 5'd13) begin failures++; $display("FAIL fcsr_then_commit got valid=%b addr=%0d required 1/13", WbValid, WbRdAddr); end
    @(posedge Clk); #1;
    wait_drain("fcsr");
    checks++; if (OutFcsr0 !== 32'h00050300) begin failures++; $display("FAIL fcsr_after_commit got %h required 00050300", OutFcsr0); end
  endtask

  task automatic test_flush();
    WbReady = 1'b0;
    for (int i = 14; i <= 16; i++) push(5'(i), 5'h0, 32'h0, 1'b0);
    Flush = 1'b1;
    @(negedge Clk);
    checks++; if (WbValid !== 1'b0 || InReady !== 1'b0) begin failures++; $display("FAIL flush_cycle got wbvalid=%b inready=%b required 0/0", WbValid, InReady); end
    @(posedge Clk); #1;
    Flush = 1'b0;
    WbReady = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (WbValid !== 1'b0) begin failures++; $display("FAIL flush_empty got wbvalid=%b required 0", WbValid); end
    checks++; if (OutFcsr0 !== 32'h00050300) begin failures++; $display("FAIL flush_fcsr0 got %h required 00050300", OutFcsr0); end
    @(posedge Clk); #1;
    drive_in(5'd20, 5'h0, 32'h0);
    @(negedge Clk);
    checks++;
    if (WbValid !== BYP || (BYP && WbRdAddr !== 5'd20)) begin
      failures++;
      $display("FAIL bypass_same_cycle got valid=%b addr=%0d required valid=%b addr=20", WbValid, WbRdAddr, BYP);
    end
    if (InReady) exp_q.push_back({5'd20, data_of(5'd20)});
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    checks++;
    if (WbValid !== !BYP) begin
      failures++;
      $display("FAIL bypass_next_cycle got valid=%b required %b", WbValid, !BYP);
    end
    @(posedge Clk); #1;
    wait_drain("bypass");
  endtask

  initial begin
    Rest = 1'b0;
    InValid = 1'b0; InRdAddr = '0; InRdData = '0; InExcFlags = '0; InPc = '0;
    WbReady = 1'b0;
    FcsrWrEn = 1'b0; FcsrWrSel = '0; FcsrWrData = '0;
    TrapAck = 1'b0; Flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_full();
    test_flags();
    test_trap();
    test_fcsr_hold();
    test_flush();
    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
